// File: rtl/sample_out_pkg.sv
// Shared definitions for the sample output stage: state encoding, register map, CTRL bits.
package sample_out_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREFILL  = 2'd1,
      ST_RUN      = 2'd2,
      ST_UNDERRUN = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_STATUS   = 2'd1;
   localparam logic [1:0] ADDR_UNDERRUN = 2'd2;
   localparam logic [1:0] ADDR_DROP     = 2'd3;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_ZOU    = 1;
   localparam int CTRL_FLUSH  = 2;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sample_out_if.sv
// Sample input, DAC output, Avalon-MM slave and Avalon-ST source of the sample output stage.
interface sample_out_if #(
   parameter int SAMPLE_W = 24
);
   logic signed [SAMPLE_W-1:0] i_sample;
   logic                       i_valid;
   logic                       o_ready;
   logic                       o_gen_clk_en;
   logic [1:0]                 avs_s0_address;
   logic                       avs_s0_read;
   logic                       avs_s0_write;
   logic [31:0]                avs_s0_writedata;
   logic [31:0]                avs_s0_readdata;
   logic signed [SAMPLE_W-1:0] o_dac_sample;
   logic                       o_dac_strobe;
   logic [31:0]                aso_ss0_data;
   logic                       aso_ss0_valid;
   logic                       aso_ss0_ready;

   modport master (
      output i_sample, i_valid, avs_s0_address, avs_s0_read, avs_s0_write,
             avs_s0_writedata, aso_ss0_ready,
      input  o_ready, o_gen_clk_en, avs_s0_readdata, o_dac_sample, o_dac_strobe,
             aso_ss0_data, aso_ss0_valid
   );

   modport slave (
      input  i_sample, i_valid, avs_s0_address, avs_s0_read, avs_s0_write,
             avs_s0_writedata, aso_ss0_ready,
      output o_ready, o_gen_clk_en, avs_s0_readdata, o_dac_sample, o_dac_strobe,
             aso_ss0_data, aso_ss0_valid
   );
endinterface

// File: rtl/sample_out_stage_sync_fifo.sv
// Single-clock FIFO with level/full/empty; head is the registered entry at the read pointer.
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/sample_out_stage.sv
// Output stage: FIFO-buffered samples released one per sample tick to a DAC and an Avalon-ST sink.
// Optional SAMPLE_OUT_STATS_EN builds the underrun and drop counters (addresses 2/3).
module sample_out_stage
   import sample_out_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int FS_HZ     = 96_000,
   parameter int SAMPLE_W  = 24,
   parameter int DEPTH     = 16,
   parameter int PREFILL   = 8,
   parameter int BYTE_SWAP = 1
) (
   input logic         clk,
   input logic         reset,
   sample_out_if.slave bus
);
   localparam int TICK_N = CLK_HZ / FS_HZ;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic [31:0]         tick_cnt;
   logic                tick;
   state_t              state;
   logic                ctrl_en;
   logic                ctrl_zou;
   logic [SAMPLE_W-1:0] head;
   logic [LW-1:0]       level;
   logic                full;
   logic                empty;
   logic                wr_ctrl;
   logic                flush;
   logic                push;
   logic                pop;
   logic                underrun_evt;
   logic                gen_en;
   logic                dac_strobe;
   logic [SAMPLE_W-1:0] dac;
   logic [31:0]         s_data;
   logic                s_valid;
   logic [31:0]         rdata;
   logic [31:0]         under_cnt;
   logic [31:0]         drop_cnt;
   logic                unused_wdata;

   // Byte order reversal applies to the sample itself; the result is then zero-extended.
   function automatic logic [31:0] stream_word(input logic [SAMPLE_W-1:0] s);
      logic [SAMPLE_W-1:0] r;
      r = s;
      if (BYTE_SWAP == 1 && (SAMPLE_W % 8) == 0) begin
         for (int i = 0; i < SAMPLE_W / 8; i++) r[8*i +: 8] = s[SAMPLE_W-8-8*i +: 8];
      end
      return 32'(r);
   endfunction

   assign tick         = (tick_cnt == 32'(TICK_N - 1));
   assign wr_ctrl      = bus.avs_s0_write && (bus.avs_s0_address == ADDR_CTRL);
   assign flush        = wr_ctrl && bus.avs_s0_writedata[CTRL_FLUSH];
   assign push         = bus.i_valid && !full && !flush;
   assign pop          = (state == ST_RUN) && ctrl_en && !flush && tick && !empty;
   assign underrun_evt = (state == ST_RUN) && ctrl_en && !flush && tick && empty;
   assign unused_wdata = ^bus.avs_s0_writedata[31:3];

   sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (bus.i_sample),
      .head  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (reset) tick_cnt <= '0;
      else       tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
   end

   // Flush outranks a cleared enable, which outranks normal sequencing.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         ctrl_en    <= 1'b0;
         ctrl_zou   <= 1'b0;
         gen_en     <= 1'b1;
         dac        <= '0;
         dac_strobe <= 1'b0;
         s_data     <= '0;
         s_valid    <= 1'b0;
      end else begin
         gen_en     <= !full;
         dac_strobe <= 1'b0;
         if (wr_ctrl) begin
            ctrl_en  <= bus.avs_s0_writedata[CTRL_ENABLE];
            ctrl_zou <= bus.avs_s0_writedata[CTRL_ZOU];
         end
         if (flush) begin
            state <= bus.avs_s0_writedata[CTRL_ENABLE] ? ST_PREFILL : ST_IDLE;
         end else if (!ctrl_en) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE:     state <= ST_PREFILL;
               ST_PREFILL:  if (int'(level) >= PREFILL) state <= ST_RUN;
               ST_RUN:      if (underrun_evt) state <= ST_UNDERRUN;
               ST_UNDERRUN: state <= ST_PREFILL;
               default:     state <= ST_IDLE;
            endcase
         end
         if (pop) begin
            dac        <= head;
            dac_strobe <= 1'b1;
         end else if (underrun_evt) begin
            if (ctrl_zou) dac <= '0;
            dac_strobe <= 1'b1;
         end
         if (pop) begin
            s_data  <= stream_word(head);
            s_valid <= 1'b1;
         end else if (s_valid && bus.aso_ss0_ready) begin
            s_valid <= 1'b0;
         end
      end
   end

`ifdef SAMPLE_OUT_STATS_EN
   logic drop_evt;
   assign drop_evt = pop && s_valid && !bus.aso_ss0_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         under_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (bus.avs_s0_write && bus.avs_s0_address == ADDR_UNDERRUN) under_cnt <= '0;
         else if (underrun_evt) under_cnt <= sat_inc(under_cnt);
         if (bus.avs_s0_write && bus.avs_s0_address == ADDR_DROP) drop_cnt <= '0;
         else if (drop_evt) drop_cnt <= sat_inc(drop_cnt);
      end
   end
`else
   assign under_cnt = '0;
   assign drop_cnt  = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (bus.avs_s0_read) begin
         case (bus.avs_s0_address)
            ADDR_CTRL:     rdata <= {30'd0, ctrl_zou, ctrl_en};
            ADDR_STATUS:   rdata <= {20'd0, empty, full, state, 8'(level)};
            ADDR_UNDERRUN: rdata <= under_cnt;
            default:       rdata <= drop_cnt;
         endcase
      end
   end

   assign bus.o_ready         = !full;
   assign bus.o_gen_clk_en    = gen_en;
   assign bus.o_dac_sample    = dac;
   assign bus.o_dac_strobe    = dac_strobe;
   assign bus.aso_ss0_data    = s_data;
   assign bus.aso_ss0_valid   = s_valid;
   assign bus.avs_s0_readdata = rdata;
endmodule

// File: tb/tb_sample_out_stage.sv
// Randomized and directed bench for sample_out_stage against a queue-based behavioural model.
module tb_sample_out_stage;
   localparam int CLK_HZ = 1000, FS_HZ = 100, SAMPLE_W = 24, DEPTH = 8, PREFILL = 4, BYTE_SWAP = 1;
   localparam int TICK_N = CLK_HZ / FS_HZ;
`ifdef SAMPLE_OUT_STATS_EN
   localparam logic [31:0] STATS = 32'd1;
`else
   localparam logic [31:0] STATS = 32'd0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sample_out_if #(.SAMPLE_W(SAMPLE_W)) bus ();

   sample_out_stage #(
      .CLK_HZ(CLK_HZ), .FS_HZ(FS_HZ), .SAMPLE_W(SAMPLE_W),
      .DEPTH(DEPTH), .PREFILL(PREFILL), .BYTE_SWAP(BYTE_SWAP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: a sample queue plus the handful of visible registers.
   logic [23:0] q[$];
   int          m_state;
   bit          m_en, m_zou, m_strobe, m_svalid, m_gen;
   int          m_cnt;
   logic [23:0] m_dac;
   logic [31:0] m_sdata, m_uc, m_dc, m_rd;

   function automatic logic [31:0] swap24(input logic [23:0] s);
      return {8'h00, s[7:0], s[15:8], s[23:16]};
   endfunction

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 1;
   endfunction

   function automatic logic [31:0] reg_value(input logic [1:0] a);
      case (a)
         2'd0: return {30'd0, m_zou, m_en};
         2'd1: return (q.size() & 32'hFF) | (32'(m_state) << 8)
                      | ((q.size() == DEPTH) ? 32'h400 : 0) | ((q.size() == 0) ? 32'h800 : 0);
         2'd2: return (STATS != 0) ? m_uc : 32'd0;
         default: return (STATS != 0) ? m_dc : 32'd0;
      endcase
   endfunction

   task automatic model_step();
      bit tick, full, empty, wr, flush, take, pending;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [23:0] incoming, popped;
      if (reset) begin
         q.delete();
         m_state = 0; m_en = 0; m_zou = 0; m_cnt = 0; m_dac = 0; m_strobe = 0;
         m_sdata = 0; m_svalid = 0; m_uc = 0; m_dc = 0; m_rd = 0; m_gen = 1;
         return;
      end
      tick     = (m_cnt == TICK_N - 1);
      full     = (q.size() == DEPTH);
      empty    = (q.size() == 0);
      wr       = bus.avs_s0_write;
      addr     = bus.avs_s0_address;
      wd       = bus.avs_s0_writedata;
      flush    = wr && addr == 2'd0 && wd[2];
      take     = bus.i_valid && !full && !flush;
      incoming = bus.i_sample;
      if (bus.avs_s0_read) m_rd = reg_value(addr);
      m_gen    = !full;
      m_cnt    = tick ? 0 : m_cnt + 1;
      m_strobe = 0;
      pending  = m_svalid && !bus.aso_ss0_ready;
      if (m_svalid && bus.aso_ss0_ready) m_svalid = 0;
      if (flush) begin
         q.delete();
         m_state = wd[0] ? 1 : 0;
      end else if (!m_en) begin
         m_state = 0;
      end else begin
         case (m_state)
            0: m_state = 1;
            1: if (q.size() >= PREFILL) m_state = 2;
            2: if (tick) begin
                  if (!empty) begin
                     popped = q.pop_front();
                     m_dac = popped; m_strobe = 1;
                     m_sdata = swap24(popped); m_svalid = 1;
                     if (pending) m_dc = sat(m_dc);
                  end else begin
                     m_state = 3;
                     if (m_zou) m_dac = 0;
                     m_strobe = 1;
                     m_uc = sat(m_uc);
                  end
               end
            default: m_state = 1;
         endcase
      end
      if (take) q.push_back(incoming);
      if (wr) begin
         case (addr)
            2'd0: begin m_en = wd[0]; m_zou = wd[1]; end
            2'd2: m_uc = 0;
            2'd3: m_dc = 0;
            default: ;
         endcase
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      chk("o_ready", {31'd0, bus.o_ready}, {31'd0, q.size() < DEPTH});
      chk("o_gen_clk_en", {31'd0, bus.o_gen_clk_en}, {31'd0, m_gen});
      chk("o_dac_sample", {8'h00, bus.o_dac_sample}, {8'h00, m_dac});
      chk("o_dac_strobe", {31'd0, bus.o_dac_strobe}, {31'd0, m_strobe});
      chk("aso_ss0_valid", {31'd0, bus.aso_ss0_valid}, {31'd0, m_svalid});
      chk("aso_ss0_data", bus.aso_ss0_data, m_sdata);
      chk("avs_s0_readdata", bus.avs_s0_readdata, m_rd);
   end

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.avs_s0_write = 1'b1; bus.avs_s0_address = a; bus.avs_s0_writedata = d;
      @(negedge clk);
      bus.avs_s0_write = 1'b0;
   endtask

   task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.avs_s0_read = 1'b1; bus.avs_s0_address = a;
      @(posedge clk); #2;
      d = bus.avs_s0_readdata;
      @(negedge clk);
      bus.avs_s0_read = 1'b0;
   endtask

   task automatic push_seq(input logic [23:0] s[$]);
      foreach (s[i]) begin
         @(negedge clk);
         bus.i_valid = 1'b1; bus.i_sample = s[i];
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_strobe(input string name, input int max_cycles);
      bit seen = 0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(posedge clk); #2;
         if (bus.o_dac_strobe) seen = 1;
      end
      if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   logic [31:0] rv;

   initial begin
      bus.i_sample = '0; bus.i_valid = 1'b0; bus.avs_s0_address = '0;
      bus.avs_s0_read = 1'b0; bus.avs_s0_write = 1'b0; bus.avs_s0_writedata = '0;
      bus.aso_ss0_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Test 1: prefill then first release
      reg_wr(2'd0, 32'd1);
      push_seq('{24'h123456, 24'h000001, 24'h000002, 24'h000003});
      reg_rd(2'd1, rv);
      chk("t1_state_run", (rv >> 8) & 32'h3, 32'd2);
      wait_strobe("t1_strobe", 30);
      chk("t1_dac", {8'h00, bus.o_dac_sample}, 32'h0012_3456);
      chk("t1_stream_data", bus.aso_ss0_data, 32'h0056_3412);
      chk("t1_stream_valid", {31'd0, bus.aso_ss0_valid}, 32'd1);

      // Test 2: overfill while idle
      do_reset();
      push_seq('{24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 24'h6, 24'h7, 24'h8, 24'h9});
      chk("t2_ready", {31'd0, bus.o_ready}, 32'd0);
      reg_rd(2'd1, rv);
      chk("t2_status", rv, 32'h0000_0408);
      chk("t2_gen_en", {31'd0, bus.o_gen_clk_en}, 32'd0);

      // Test 3: underrun with zero_on_underrun
      do_reset();
      reg_wr(2'd0, 32'd3);
      push_seq('{24'h0A0000, 24'h0B0000, 24'h0C0000, 24'h0D0000});
      repeat (5) wait_strobe("t3_strobe", 30);
      chk("t3_dac_zero", {8'h00, bus.o_dac_sample}, 32'd0);
      reg_rd(2'd2, rv);
      chk("t3_underrun_cnt", rv, STATS);
      reg_rd(2'd1, rv);
      chk("t3_status", rv, 32'h0000_0900);
      push_seq('{24'hABCDEF, 24'h111111, 24'h222222});
      repeat (25) @(negedge clk);
      chk("t3_dac_hold", {8'h00, bus.o_dac_sample}, 32'd0);
      push_seq('{24'h333333});
      wait_strobe("t3_restart", 30);
      chk("t3_dac_restart", {8'h00, bus.o_dac_sample}, 32'h00AB_CDEF);

      // Test 4: stream back-pressure and drop
      do_reset();
      bus.aso_ss0_ready = 1'b0;
      reg_wr(2'd0, 32'd1);
      push_seq('{24'h010203, 24'h0A0B0C, 24'h040506, 24'h070809});
      repeat (2) wait_strobe("t4_strobe", 30);
      chk("t4_valid_held", {31'd0, bus.aso_ss0_valid}, 32'd1);
      chk("t4_data_second", bus.aso_ss0_data, 32'h000C_0B0A);
      reg_rd(2'd3, rv);
      chk("t4_drop_cnt", rv, STATS);
      @(negedge clk); bus.aso_ss0_ready = 1'b1;
      @(posedge clk); #2;
      chk("t4_valid_cleared", {31'd0, bus.aso_ss0_valid}, 32'd0);

      // Test 5: flush with simultaneous push
      do_reset();
      push_seq('{24'h1, 24'h2, 24'h3, 24'h4, 24'h5});
      @(negedge clk);
      bus.avs_s0_write = 1'b1; bus.avs_s0_address = 2'd0; bus.avs_s0_writedata = 32'h5;
      bus.i_valid = 1'b1; bus.i_sample = 24'h777777;
      @(negedge clk);
      bus.avs_s0_write = 1'b0; bus.i_valid = 1'b0;
      reg_rd(2'd1, rv);
      chk("t5_status", rv, 32'h0000_0900);
      reg_rd(2'd0, rv);
      chk("t5_ctrl", rv, 32'd1);

      // Test 6: reset while the stream word is pending
      do_reset();
      bus.aso_ss0_ready = 1'b0;
      reg_wr(2'd0, 32'd1);
      push_seq('{24'h5A5A5A, 24'h2, 24'h3, 24'h4});
      wait_strobe("t6_strobe", 30);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #2;
      chk("t6_dac", {8'h00, bus.o_dac_sample}, 32'd0);
      chk("t6_strobe", {31'd0, bus.o_dac_strobe}, 32'd0);
      chk("t6_valid", {31'd0, bus.aso_ss0_valid}, 32'd0);
      chk("t6_data", bus.aso_ss0_data, 32'd0);
      chk("t6_ready", {31'd0, bus.o_ready}, 32'd1);
      chk("t6_gen_en", {31'd0, bus.o_gen_clk_en}, 32'd1);
      @(negedge clk); reset = 1'b0;
      reg_rd(2'd1, rv);
      chk("t6_status", rv, 32'h0000_0800);
      reg_rd(2'd2, rv);
      chk("t6_underrun_cnt", rv, 32'd0);
      reg_rd(2'd3, rv);
      chk("t6_drop_cnt", rv, 32'd0);

      // Random phase: varying push rate, stream ready and register traffic
      do_reset();
      reg_wr(2'd0, 32'd1);
      for (int seg = 0; seg < 10; seg++) begin
         int rate;
         rate = $urandom_range(2, 16);
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            bus.i_valid       = ($urandom_range(0, rate - 1) == 0);
            bus.i_sample      = 24'($urandom);
            bus.aso_ss0_ready = ($urandom_range(0, 3) != 0);
            bus.avs_s0_read   = ($urandom_range(0, 3) == 0);
            bus.avs_s0_write  = ($urandom_range(0, 59) == 0);
            bus.avs_s0_address = bus.avs_s0_write && ($urandom_range(0, 2) != 0)
                                 ? 2'd0 : 2'($urandom_range(0, 3));
            bus.avs_s0_writedata = {29'($urandom), ($urandom_range(0, 7) == 0),
                                    1'($urandom), ($urandom_range(0, 7) != 0)};
         end
      end
      @(negedge clk);
      bus.i_valid = 1'b0; bus.avs_s0_read = 1'b0; bus.avs_s0_write = 1'b0;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
